// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer owning the PC, feeding a small fetch queue to decode.
// Ports: clk/reset (sync, active-high); fetch_en gates new fetches; imem_addr/imem_data form the
// single-cycle memory read; redirect_valid/redirect_target flush the queue and reload the PC;
// out_valid/out_ready/out_instr/out_pc hand the queue head to decode; fault is sticky when the PC
// leaves memory. Optional macro IFETCH_PERF_EN adds perf_fetch_cnt/perf_stall_cnt counters.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic          fault_q, fault_d;
    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic [31:0]   pc_mem_q [FIFO_DEPTH];
    logic          in_range, full, pop, can_fetch, push;
    always_comb begin
        in_range  = {2'b00, pc_q[31:2]} < 32'(MEM_WORDS);
        full      = cnt_q == CW'(FIFO_DEPTH);
        pop       = out_valid & out_ready;
        can_fetch = fetch_en & ~redirect_valid & ~fault_q & in_range;
        // a full queue still accepts a fetch when the head leaves the same cycle
        push      = can_fetch & (~full | pop);
        pc_d      = redirect_valid ? (redirect_target & ~32'h3) : push ? pc_q + 32'd4 : pc_q;
        fault_d   = redirect_valid ? 1'b0 : fault_q | (fetch_en & ~in_range);
        cnt_d     = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
        head_d    = redirect_valid ? '0 : head_q + PW'(pop);
        tail_d    = redirect_valid ? '0 : tail_q + PW'(push);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fault_q <= fault_d;
        end
    end
    // payload storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[tail_q] <= imem_data;
            pc_mem_q[tail_q]    <= pc_q;
        end
    end
    assign imem_addr = pc_q;
    assign out_valid = cnt_q != '0;
    assign out_instr = out_valid ? instr_mem_q[head_q] : 32'h0;
    assign out_pc    = out_valid ? pc_mem_q[head_q] : 32'h0;
    assign fault     = fault_q;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(push);
            perf_stall_q <= perf_stall_q + 32'(can_fetch & ~push);
        end
    end
    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: scoreboard bench for imem_fetch_ctrl with default parameters.
module tb_imem_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset, fetch_en, redirect_valid, out_ready;
    logic [31:0] redirect_target, imem_addr, imem_data, out_instr, out_pc;
    logic        out_valid, fault;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif
    logic [31:0] mem [1024];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          n_pop = 0;
    int          base;

    imem_fetch_ctrl dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .fault(fault)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr[31:2] < 30'd1024) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pcs(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
    endtask

    task automatic drain();
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && out_valid; i++) step();
        chk("drained_valid", {31'b0, out_valid}, 32'd0);
        chk("sb_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
        step();
        redirect_valid  = 1'b0;
    endtask

    // scoreboard: every accepted head must be the next expected pc with its memory word
    always @(negedge clk) begin
        if (!reset && !redirect_valid && out_valid && out_ready) begin
            logic [31:0] e;
            n_pop++;
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e);
                chk("out_instr", out_instr, mem[e[11:2]]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h8c01_0001 + 32'(i);
        reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        step(2);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        reset = 1'b0;
        step();
        chk("idle_valid", {31'b0, out_valid}, 32'd0);

        // streaming, no bubbles
        fetch_en = 1'b1; out_ready = 1'b1; base = n_pop;
        expect_pcs(32'h0, 8);
        step();
        chk("stream_valid1", {31'b0, out_valid}, 32'd1);
        chk("stream_pc0", out_pc, 32'h0);
        step(7);
        fetch_en = 1'b0;
        step();
        chk("stream_count", 32'(n_pop - base), 32'd8);
        chk("stream_addr", imem_addr, 32'h20);
        drain();

        // backpressure: queue fills, pc holds
        fetch_en = 1'b1; out_ready = 1'b0;
        step(5);
        chk("bp_addr", imem_addr, 32'h28);
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_head", out_pc, 32'h20);
        expect_pcs(32'h20, 6);
        out_ready = 1'b1;
        step(4);
        drain();

        // redirect with simultaneous pop
        fetch_en = 1'b1; out_ready = 1'b0;
        redirect_to(32'h14);
        step(2);
        chk("rd_full_addr", imem_addr, 32'h1c);
        chk("rd_head", out_pc, 32'h14);
        out_ready = 1'b1;
        expect_pcs(32'h10, 2);
        redirect_to(32'h11);
        chk("rd_addr", imem_addr, 32'h10);
        chk("rd_flushed", {31'b0, out_valid}, 32'd0);
        step();
        chk("rd_first", out_pc, 32'h10);
        step();
        drain();

        // boundary: fault at end of memory, redirect recovers
        fetch_en = 1'b1; out_ready = 1'b1;
        expect_pcs(32'hFF8, 2);
        redirect_to(32'hFF8);
        step(3);
        chk("bnd_fault", {31'b0, fault}, 32'd1);
        chk("bnd_valid", {31'b0, out_valid}, 32'd0);
        chk("bnd_addr", imem_addr, 32'h1000);
        step(2);
        chk("bnd_hold_addr", imem_addr, 32'h1000);
        chk("bnd_sticky", {31'b0, fault}, 32'd1);
        chk("bnd_sb", 32'(exp_q.size()), 32'd0);
        expect_pcs(32'h0, 2);
        redirect_to(32'h0);
        chk("bnd_clear", {31'b0, fault}, 32'd0);
        chk("bnd_resume", imem_addr, 32'h0);
        step(2);
        drain();

        // reset mid-operation with a full queue
        fetch_en = 1'b1; out_ready = 1'b0;
        redirect_to(32'h18);
        step(2);
        chk("mr_addr", imem_addr, 32'h20);
        chk("mr_full", {31'b0, out_valid}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_valid", {31'b0, out_valid}, 32'd0);
        chk("mr_fault", {31'b0, fault}, 32'd0);
        chk("mr_addr_rst", imem_addr, 32'h0);
        out_ready = 1'b1;
        expect_pcs(32'h0, 2);
        step(2);
        drain();

        // fetch_en gating
        fetch_en = 1'b1; out_ready = 1'b1;
        expect_pcs(32'h8, 4);
        step(2);
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gate_addr", imem_addr, 32'h10);
        end
        chk("gate_valid", {31'b0, out_valid}, 32'd0);
        fetch_en = 1'b1;
        step(2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
